// File: rtl/up_input_port.sv
// Operator keypad receive port: synchronises Enter, captures one Input byte per pulse into a FWFT FIFO.
// Latency: Enter first sampled high at edge k -> byte pushed at edge k+2 (k+1+DEBOUNCE_CYC with debounce).
// Backpressure: Ready/Rd pop handshake; a capture into a full FIFO with no pop is dropped and sets sticky Overflow.
// Optional build macro UP_INPUT_PORT_DEBOUNCE_EN adds QUAL/REL debounce states on both Enter edges.
module up_input_port #(
  parameter int DEPTH        = 4,
  parameter int DATA_W       = 8,
  parameter int DEBOUNCE_CYC = 3
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              Enter,
  input  logic [DATA_W-1:0] Input,
  input  logic              Rd,
  output logic [DATA_W-1:0] Data,
  output logic              Ready,
  output logic              Full,
  output logic              Overflow,
  input  logic              OvfClr
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  // Elaboration-time parameter sanity
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("up_input_port: DEPTH must be a power of two >= 2");
  end
  if (DEBOUNCE_CYC < 1) begin : g_bad_debounce
    $error("up_input_port: DEBOUNCE_CYC must be >= 1");
  end

  // ---------------------------------------------------------------------
  // Enter synchroniser
  // ---------------------------------------------------------------------
  logic s1_q;
  logic s2_q;

  // Two-flop synchroniser; resets to 1 so an Enter held through reset looks already held
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= Enter;
      s2_q <= s1_q;
    end
  end

  // ---------------------------------------------------------------------
  // Capture FSM
  // ---------------------------------------------------------------------
  logic push_d;

`ifdef UP_INPUT_PORT_DEBOUNCE_EN
  typedef enum logic [1:0] {ST_IDLE, ST_QUAL, ST_HELD, ST_REL} state_t;

  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_INC  = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next state: cnt counts consecutive stable s2 samples while qualifying either edge
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    push_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (s2_q) begin
          if (CNT_LAST == '0) begin
            push_d  = 1'b1;
            state_d = ST_HELD;
            cnt_d   = '0;
          end else begin
            state_d = ST_QUAL;
            cnt_d   = CNT_INC;
          end
        end
      end
      ST_QUAL: begin
        if (!s2_q) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          push_d  = 1'b1;
          state_d = ST_HELD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_INC;
        end
      end
      ST_HELD: begin
        if (!s2_q) begin
          if (CNT_LAST == '0) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            state_d = ST_REL;
            cnt_d   = CNT_INC;
          end
        end
      end
      ST_REL: begin
        if (s2_q) begin
          state_d = ST_HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_INC;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State register; reset parks in HELD so Enter must be seen low before the first capture
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_HELD;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
`else
  typedef enum logic {ST_IDLE, ST_HELD} state_t;

  state_t state_q, state_d;

  // Next state: the IDLE->HELD transition is the single push for this pulse
  always_comb begin
    state_d = state_q;
    push_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (s2_q) begin
          push_d  = 1'b1;
          state_d = ST_HELD;
        end
      end
      ST_HELD: begin
        if (!s2_q) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; reset parks in HELD so Enter must be seen low before the first capture
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_HELD;
    end else begin
      state_q <= state_d;
    end
  end
`endif

  // ---------------------------------------------------------------------
  // FWFT FIFO
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [AW:0]       count_q;
  logic              ovf_q;
  logic              pop_w;
  logic              wr_en_w;
  logic              ovf_set_w;

  assign Ready     = (count_q != '0);
  assign Full      = (count_q == DEPTH_C);
  assign pop_w     = Rd & Ready;
  // A pop in the same edge frees the slot, so push-at-full with Rd is legal
  assign wr_en_w   = push_d & (~Full | pop_w);
  assign ovf_set_w = push_d & Full & ~pop_w;
  assign Data      = Ready ? mem_q[rd_ptr_q] : '0;
  assign Overflow  = ovf_q;

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en_w) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop_w)   rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({wr_en_w, pop_w})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; contents are don't-care until written, Data is masked when empty
  always_ff @(posedge CLOCK) begin
    if (wr_en_w) mem_q[wr_ptr_q] <= Input;
  end

  // Sticky overflow flag; a new drop wins over a same-edge clear
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      ovf_q <= 1'b0;
    end else if (ovf_set_w) begin
      ovf_q <= 1'b1;
    end else if (OvfClr) begin
      ovf_q <= 1'b0;
    end
  end

endmodule
